// File: rtl/sram_scan_requester.sv
// Raster-scan read requester: walks (x,y), issues throttled reads, tags returns with coordinates.
// Optional SCAN_STALL_STATS_EN adds stall_clear/stall_count (blocked-slot counter).
module sram_scan_requester #(
  parameter int unsigned COORD_W         = 11,
  parameter int unsigned PIXEL_W         = 16,
  parameter int unsigned H_TOTAL         = 1056,
  parameter int unsigned V_TOTAL         = 628,
  parameter int unsigned REQ_DIV         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  output logic                           request_active,
  output logic [COORD_W-1:0]             request_x,
  output logic [COORD_W-1:0]             request_y,
  input  logic                           request_ready,
  input  logic [PIXEL_W-1:0]             request_data,
  input  logic                           out_fifo_prog_full,
  output logic                           out_fifo_write,
  output logic [2*COORD_W+PIXEL_W-1:0]   out_fifo_data,
  output logic                           frame_start,
  output logic                           tag_error
`ifdef SCAN_STALL_STATS_EN
  ,
  input  logic                           stall_clear,
  output logic [31:0]                    stall_count
`endif
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DIV_W = (REQ_DIV > 1) ? $clog2(REQ_DIV) : 1;

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(REQ_DIV - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  logic [DIV_W-1:0]             r_div;
  logic [COORD_W-1:0]           r_x;
  logic [COORD_W-1:0]           r_y;
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [CNT_W-1:0]             r_outstanding;
  logic [COORD_W-1:0]           r_tag_x [MAX_OUTSTANDING];
  logic [COORD_W-1:0]           r_tag_y [MAX_OUTSTANDING];

  logic                         r_req_active;
  logic [COORD_W-1:0]           r_req_x;
  logic [COORD_W-1:0]           r_req_y;
  logic                         r_frame_start;
  logic                         r_wr;
  logic [2*COORD_W+PIXEL_W-1:0] r_wr_data;
  logic                         r_tag_error;

  logic w_due;
  logic w_take;
  logic w_blocked;
  logic w_div_adv;
  logic w_pop;

  // A blocked slot freezes div_cnt; an abandoned slot (enable low) lets it run on.
  always_comb begin
    w_due     = (r_div == '0);
    w_take    = w_due & enable & (r_outstanding < CNT_MAX) & ~out_fifo_prog_full;
    w_blocked = w_due & enable & ~w_take;
    w_div_adv = ~w_blocked;
    w_pop     = request_ready & (r_outstanding != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      if (w_div_adv)
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      if (w_take) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + COORD_W'(1);
        end else begin
          r_x <= r_x + COORD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_take) begin
      r_tag_x[r_wr_ptr] <= r_x;
      r_tag_y[r_wr_ptr] <= r_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_take)
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_take, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_active  <= 1'b0;
      r_req_x       <= '0;
      r_req_y       <= '0;
      r_frame_start <= 1'b0;
      r_wr          <= 1'b0;
      r_wr_data     <= '0;
      r_tag_error   <= 1'b0;
    end else begin
      r_req_active  <= w_take;
      r_frame_start <= w_take & (r_x == '0) & (r_y == '0);
      if (w_take) begin
        r_req_x <= r_x;
        r_req_y <= r_y;
      end
      r_wr <= w_pop;
      if (w_pop)
        r_wr_data <= {r_tag_x[r_rd_ptr], r_tag_y[r_rd_ptr], request_data};
      if (request_ready && (r_outstanding == '0))
        r_tag_error <= 1'b1;
    end
  end

  assign request_active = r_req_active;
  assign request_x      = r_req_x;
  assign request_y      = r_req_y;
  assign frame_start    = r_frame_start;
  assign out_fifo_write = r_wr;
  assign out_fifo_data  = r_wr_data;
  assign tag_error      = r_tag_error;

`ifdef SCAN_STALL_STATS_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (reset || stall_clear)
      r_stall_count <= '0;
    else if (w_blocked && (r_stall_count != '1))
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`endif

endmodule
